step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have parameter PHASE_DIV, default 8'd4, meaning clk cycles per phase advance (legal range 1..255).
REQ-002 The block SHALL have parameter HOLD, default 1'b0, meaning coils stay energized at the current phase while run=0 (1) or are de-energized (0).
REQ-003 Port: clk  input  1  motor clock; all logic on posedge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: run  input  1  rotate enable, driven by the quarter-turn window counter output.
REQ-006 Port: step  input  1  step mode; 1 = full step, 0 = half step.
REQ-007 Port: dir  input  1  direction; 1 = forward (index increments), 0 = reverse (index decrements).
REQ-008 Port: coil  output  4  coil drive {A, B, A_n, B_n}, registered.
REQ-009 Port: phase_idx  output  3  current phase-table index, registered.
REQ-010 Port: step_pulse  output  1  one-cycle strobe on every phase advance, registered.
REQ-011 Port: step_count  output  8  phase advances since the last run rising edge, saturating at 255, registered.

Function
REQ-012 The phase table SHALL be: idx 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001 (bit order {A,B,A_n,B_n}).
REQ-013 An internal divider div_cnt (8 bit) SHALL increment each cycle run=1; the cycle div_cnt==PHASE_DIV-1 is an advance cycle, and div_cnt SHALL return to 0 on that cycle.
REQ-014 While run=0, div_cnt SHALL be held at 0, so the first advance occurs on the PHASE_DIV-th cycle of run high (PHASE_DIV=1: every run-high cycle advances).
REQ-015 On an advance cycle, step and dir SHALL be sampled on that same cycle; mid-rotation changes take effect at the next advance.
REQ-016 Half step (step=0): idx SHALL move by 1, modulo 8.
REQ-017 Full step (step=1) from an odd idx: idx SHALL move by 2, modulo 8 (two-coil-on positions only).
REQ-018 Full step from an even idx: idx SHALL move by 1 in the selected direction (alignment to an odd idx), then by 2 thereafter.
REQ-019 Wrap-around: forward from 7 SHALL go to 0 (half) or 1 (full); reverse from 0 SHALL go to 7 (either mode, alignment rule); reverse full from 1 SHALL go to 7.
REQ-020 coil SHALL be updated every cycle to TABLE[idx after this cycle's update] when run=1 or HOLD=1, else 4'b0000; coil and phase_idx change on the same edge.
REQ-021 step_pulse SHALL be 1 exactly on the edge where phase_idx changes, 0 otherwise.
REQ-022 step_count SHALL be cleared on the cycle run goes 0->1 (run=1, previous run=0); an advance on that same cycle (PHASE_DIV=1) SHALL load 1 instead of 0.
REQ-023 step_count SHALL increment on each advance and hold at 255; it SHALL hold its value while run=0.
REQ-024 phase_idx SHALL be retained across run low periods (no re-homing).
REQ-025 Output coil SHALL never assert A with A_n or B with B_n simultaneously.

Reset
REQ-026 When rst=1 at a clk edge: phase_idx=0, coil=0000, step_pulse=0, step_count=0, div_cnt=0, previous-run register=0, regardless of run.
REQ-027 rst SHALL take priority over any advance in the same cycle; reset mid-rotation aborts it, and rotation resumes from idx 0 with a fresh divider only when rst=0 and run=1.

Verification
REQ-028 Reset, PHASE_DIV=4, HOLD=0, step=0, dir=1, run=1 for 12 cycles -> advances on cycles 4, 8, 12; phase_idx 1,2,3; coil 1100,0100,0110; step_count=3; one step_pulse each.
REQ-029 From idx 0, step=1, dir=1, run high for 5 advances -> phase_idx 1,3,5,7,1; coil 1100,0110,0011,1001,1100.
REQ-030 From idx 0, step=0, dir=0, 2 advances -> phase_idx 7, 6; coil 1001, 0001.
REQ-031 run dropped mid-rotation at idx 3, HOLD=0 -> coil=0000 next edge, phase_idx stays 3, step_count held; HOLD=1 -> coil stays 0110; run reasserted -> step_count cleared, first advance after 4 cycles to idx 4.
REQ-032 PHASE_DIV=1, run held 300 cycles -> step_pulse every cycle, step_count saturates at 255, phase_idx wraps 7->0 repeatedly.
REQ-033 rst=1 asserted on an advance cycle -> next edge phase_idx=0, coil=0000, step_pulse=0, step_count=0; no advance recorded.

Source files
------------

// File: rtl/step_sequencer.sv
// Stepper motor phase sequencer.
// Walks an 8-entry coil table (half or full step, either direction) at a
// programmable clock divide, emits a strobe per phase advance and counts
// advances since rotation was last enabled.
module step_sequencer #(
    parameter logic [7:0] PHASE_DIV = 8'd4,  // clk cycles per phase advance, 1..255
    parameter logic       HOLD      = 1'b0   // 1: keep coils energized while run=0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] coil,
    output logic [2:0] phase_idx,
    output logic       step_pulse,
    output logic [7:0] step_count
);

    typedef enum logic {
        HALF_STEP = 1'b0,
        FULL_STEP = 1'b1
    } step_mode_e;

    typedef enum logic {
        REVERSE = 1'b0,
        FORWARD = 1'b1
    } direction_e;

    localparam logic [7:0] DIV_LAST  = PHASE_DIV - 8'd1;
    localparam logic [7:0] COUNT_MAX = 8'hFF;

    // Coil pattern {A, B, A_n, B_n} for each phase index. Adjacent entries
    // never energize a coil and its complement together.
    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        logic [3:0] pattern;
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
        return pattern;
    endfunction

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       run_q,     run_d;
    logic [2:0] idx_q,     idx_d;
    logic [3:0] coil_q,    coil_d;
    logic       pulse_q,   pulse_d;
    logic [7:0] count_q,   count_d;

    logic       advance;
    logic       run_rise;
    logic [2:0] stride;
    step_mode_e mode;
    direction_e direction;

    assign mode      = step_mode_e'(step);
    assign direction = direction_e'(dir);

    // Divider, phase stepping, coil lookup and advance counting.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        div_cnt_d = 8'd0;
        run_d     = run;
        idx_d     = idx_q;
        coil_d    = 4'b0000;
        pulse_d   = 1'b0;
        count_d   = count_q;
        stride    = 3'd1;

        // The divider only runs while run is high, so the first advance
        // lands on the PHASE_DIV-th run-high cycle.
        advance  = run && (div_cnt_q == DIV_LAST);
        run_rise = run && !run_q;

        if (run && !advance) begin
            div_cnt_d = div_cnt_q + 8'd1;
        end

        // Full step moves by two only from an odd (two-coil) position; from
        // an even position it first moves by one to align onto an odd index.
        if (mode == FULL_STEP && idx_q[0]) begin
            stride = 3'd2;
        end

        // 3-bit arithmetic gives the modulo-8 wrap in both directions.
        if (advance) begin
            if (direction == FORWARD) begin
                idx_d = idx_q + stride;
            end else begin
                idx_d = idx_q - stride;
            end
        end

        if (run || HOLD) begin
            coil_d = coil_pattern(idx_d);
        end

        // Every advance moves the index by a non-zero amount, so the strobe
        // coincides exactly with the index changing.
        pulse_d = advance;

        if (run_rise) begin
            count_d = advance ? 8'd1 : 8'd0;
        end else if (advance && count_q != COUNT_MAX) begin
            count_d = count_q + 8'd1;
        end
    end

    // State register with synchronous reset taking priority over an advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            div_cnt_q <= 8'd0;
            run_q     <= 1'b0;
            idx_q     <= 3'd0;
            coil_q    <= 4'b0000;
            pulse_q   <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            run_q     <= run_d;
            idx_q     <= idx_d;
            coil_q    <= coil_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
        end
    end

    assign coil       = coil_q;
    assign phase_idx  = idx_q;
    assign step_pulse = pulse_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer. Four instances with different
// divide/hold settings share the same stimulus; each is compared every cycle
// against a table-driven behavioural model, plus directed expectations.
module tb_step_sequencer;

    localparam int NI = 4;
    // inst0: div 4 no hold, inst1: div 4 hold, inst2: div 1 no hold, inst3: div 3 hold
    localparam logic [8*NI-1:0] DIVS  = {8'd3, 8'd1, 8'd4, 8'd4};
    localparam logic [NI-1:0]   HOLDS = 4'b1010;

    logic clk = 1'b0;
    logic rst, run, step, dir;

    logic [4*NI-1:0] coil_w;
    logic [3*NI-1:0] idx_w;
    logic [NI-1:0]   pulse_w;
    logic [8*NI-1:0] cnt_w;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        step_sequencer #(
            .PHASE_DIV(DIVS[g*8 +: 8]),
            .HOLD     (HOLDS[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .run       (run),
            .step      (step),
            .dir       (dir),
            .coil      (coil_w[g*4 +: 4]),
            .phase_idx (idx_w[g*3 +: 3]),
            .step_pulse(pulse_w[g]),
            .step_count(cnt_w[g*8 +: 8])
        );
    end

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference model: per-instance divider count, index as an
    // integer position 0..7, and the phase table looked up by position.
    logic [3:0] phase_tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int         m_div   [NI];
    int         m_idx   [NI];
    int         m_cnt   [NI];
    bit         m_prev  [NI];
    bit         m_pulse [NI];
    logic [3:0] m_coil  [NI];

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            int p;
            int move;
            bit adv;
            p = int'(DIVS[k*8 +: 8]);
            if (rst) begin
                m_div[k]   = 0;
                m_idx[k]   = 0;
                m_cnt[k]   = 0;
                m_prev[k]  = 0;
                m_pulse[k] = 0;
                m_coil[k]  = 4'b0000;
            end else begin
                adv = run && (m_div[k] == p - 1);
                m_div[k] = (run && !adv) ? m_div[k] + 1 : 0;
                if (adv) begin
                    move = (step && (m_idx[k] % 2 == 1)) ? 2 : 1;
                    m_idx[k] = dir ? (m_idx[k] + move) % 8 : (m_idx[k] - move + 8) % 8;
                end
                m_coil[k]  = (run || HOLDS[k]) ? phase_tbl[m_idx[k]] : 4'b0000;
                m_pulse[k] = adv;
                if (run && !m_prev[k]) begin
                    m_cnt[k] = adv ? 1 : 0;
                end else if (adv && m_cnt[k] < 255) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                m_prev[k] = run;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] c;
        for (int k = 0; k < NI; k++) begin
            c = coil_w[k*4 +: 4];
            check($sformatf("coil[%0d]", k),  c,                     m_coil[k]);
            check($sformatf("idx[%0d]", k),   idx_w[k*3 +: 3],       m_idx[k]);
            check($sformatf("pulse[%0d]", k), pulse_w[k],            m_pulse[k]);
            check($sformatf("count[%0d]", k), cnt_w[k*8 +: 8],       m_cnt[k]);
            check($sformatf("legal[%0d]", k), (c[3] & c[1]) | (c[2] & c[0]), 0);
        end
    endtask

    // One clock: inputs already stable, update the model, sample after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int         npulse;
    int         nwrap;
    logic [2:0] prev_idx;
    int         e28_idx [3]  = '{1, 2, 3};
    logic [3:0] e28_coil [3] = '{4'b1100, 4'b0100, 4'b0110};
    int         e29_idx [5]  = '{1, 3, 5, 7, 1};
    logic [3:0] e29_coil [5] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
    int         e30_idx [2]  = '{7, 6};
    logic [3:0] e30_coil [2] = '{4'b1001, 4'b0001};

    initial begin
        rst  = 1'b1;
        run  = 1'b1;
        step = 1'b0;
        dir  = 1'b1;

        // Reset state, with run high during reset.
        do_reset(2);
        check("rst_idx",   idx_w,   0);
        check("rst_coil",  coil_w,  0);
        check("rst_pulse", pulse_w, 0);
        check("rst_count", cnt_w,   0);

        // Half step forward, divide by 4, 12 cycles.
        step = 1'b0; dir = 1'b1; run = 1'b1; npulse = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            npulse += int'(pulse_w[0]);
            if (c % 4 == 0) begin
                check("r28_idx",  idx_w[2:0],  e28_idx[c/4-1]);
                check("r28_coil", coil_w[3:0], e28_coil[c/4-1]);
            end
        end
        check("r28_count",  cnt_w[7:0], 3);
        check("r28_pulses", npulse,     3);

        // Full step forward from idx 0: align then stride 2 with wrap.
        run = 1'b0;
        do_reset(1);
        step = 1'b1; dir = 1'b1; run = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c % 4 == 0) begin
                check("r29_idx",  idx_w[2:0],  e29_idx[c/4-1]);
                check("r29_coil", coil_w[3:0], e29_coil[c/4-1]);
            end
        end

        // Half step reverse from idx 0 wraps to 7.
        run = 1'b0;
        do_reset(1);
        step = 1'b0; dir = 1'b0; run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c % 4 == 0) begin
                check("r30_idx",  idx_w[2:0],  e30_idx[c/4-1]);
                check("r30_coil", coil_w[3:0], e30_coil[c/4-1]);
            end
        end

        // Run dropped at idx 3, with and without hold, then reasserted.
        run = 1'b0;
        do_reset(1);
        step = 1'b0; dir = 1'b1; run = 1'b1;
        repeat (12) tick();
        run = 1'b0;
        tick();
        check("r31_coil_nohold", coil_w[3:0], 4'b0000);
        check("r31_coil_hold",   coil_w[7:4], 4'b0110);
        check("r31_idx0",        idx_w[2:0],  3);
        check("r31_idx1",        idx_w[5:3],  3);
        check("r31_cnt0",        cnt_w[7:0],  3);
        repeat (3) tick();
        check("r31_idx_held",    idx_w[2:0],  3);
        check("r31_cnt_held",    cnt_w[15:8], 3);
        run = 1'b1;
        tick();
        check("r31_cnt_clr0", cnt_w[7:0],  0);
        check("r31_cnt_clr1", cnt_w[15:8], 0);
        repeat (3) tick();
        check("r31_resume0", idx_w[2:0], 4);
        check("r31_resume1", idx_w[5:3], 4);
        check("r31_rcnt",    cnt_w[7:0], 1);

        // Divide by 1: pulse every cycle, saturating count, repeated wrap.
        run = 1'b0;
        do_reset(1);
        step = 1'b0; dir = 1'b1; run = 1'b1;
        npulse = 0; nwrap = 0;
        prev_idx = idx_w[8:6];
        for (int c = 1; c <= 300; c++) begin
            tick();
            npulse += int'(pulse_w[2]);
            if (prev_idx == 3'd7 && idx_w[8:6] == 3'd0) nwrap++;
            prev_idx = idx_w[8:6];
        end
        check("r32_pulses", npulse,       300);
        check("r32_wraps",  nwrap,        37);
        check("r32_sat",    cnt_w[23:16], 255);

        // Reset on an advance cycle wins over the advance.
        run = 1'b0;
        do_reset(1);
        run = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("r33_idx",   idx_w,   0);
        check("r33_coil",  coil_w,  0);
        check("r33_pulse", pulse_w, 0);
        check("r33_count", cnt_w,   0);
        rst = 1'b0;
        repeat (4) tick();
        check("r33_resume", idx_w[2:0], 1);

        // Randomized operation with occasional resets and mode changes.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) run  = ~run;
            if ($urandom_range(0, 9)  == 0) step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9)  == 0) dir  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
